// File: rtl/uart_pkg.sv
// Shared UART constants and the receiver state encoding.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Byte storage for the receive FIFO: synchronous write port, asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH  = UART_FIFO_DEPTH,
  parameter  int DATA_W = UART_DATA_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with sticky overflow flag.
// Define UART_RX_FIFO_STATS_EN to add the saturating drop_count output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH  = UART_FIFO_DEPTH,
  parameter  int DATA_W = UART_DATA_W,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  input  logic              clear_overflow
`ifdef UART_RX_FIFO_STATS_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   rd_ptr;
  logic [DATA_W-1:0] rd_data;
  logic              do_pop;
  logic              do_wr;
  logic              drop;

  // Flags come only from registered pointers; in_valid never reaches them.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : rd_data;

  assign do_pop = out_valid && out_ready;
  assign do_wr  = in_valid && (!full || do_pop);
  assign drop   = in_valid && full && !do_pop;

  uart_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk   (clk),
    .we    (do_wr),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (in_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_wr && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_wr) begin
        count <= count - 1'b1;
      end
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop) begin
      drop_count <= clear_overflow ? 16'd1 : sat_inc16(drop_count);
    end else if (clear_overflow) begin
      drop_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: directed writes push expected bytes, a monitor checks pops.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              clear_overflow;
`ifdef UART_RX_FIFO_STATS_EN
  logic [15:0]       drop_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q [$];

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
`ifdef UART_RX_FIFO_STATS_EN
    ,
    .drop_count     (drop_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write strobe; the expected byte is queued only when the model says it is kept.
  task automatic wr(input logic [7:0] b, input bit keep);
    in_valid = 1'b1;
    in_data  = b;
    if (keep) exp_q.push_back(b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int exp_cycles, input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (!empty && n < 40) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk(name, n, exp_cycles);
  endtask

  // Monitor: sampled mid-cycle, a handshake here is the pop at the next edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pop: got 0x%0h, expected no output", out_data);
      end else begin
        chk("pop_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset          = 1'b1;
    in_data        = '0;
    in_valid       = 1'b0;
    out_ready      = 1'b0;
    clear_overflow = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_empty", empty, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_full", full, 0);

    // Single byte, visible the cycle after the write edge.
    wr(8'hA5, 1'b1);
    chk("one_out_valid", out_valid, 1);
    chk("one_out_data", out_data, 8'hA5);
    chk("one_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("one_empty_after_pop", empty, 1);
    chk("one_count_after_pop", count, 0);

    // Fill to capacity.
    for (int i = 0; i < DEPTH; i++) wr(8'(i), 1'b1);
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);
    chk("fill_out_data_head", out_data, 8'h00);

    // Drops while full, including a drop coinciding with clear_overflow.
    wr(8'hFF, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 16);
`ifdef UART_RX_FIFO_STATS_EN
    chk("ovf_drop_count1", drop_count, 1);
`endif
    wr(8'hFE, 1'b0);
`ifdef UART_RX_FIFO_STATS_EN
    chk("ovf_drop_count2", drop_count, 2);
`endif
    clear_overflow = 1'b1;
    wr(8'hFD, 1'b0);
    clear_overflow = 1'b0;
    chk("ovf_set_wins", overflow, 1);
`ifdef UART_RX_FIFO_STATS_EN
    chk("ovf_drop_count_set1", drop_count, 1);
`endif
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("ovf_cleared", overflow, 0);
`ifdef UART_RX_FIFO_STATS_EN
    chk("ovf_drop_count_cleared", drop_count, 0);
`endif
    chk("ovf_count_kept", count, 16);

    // Drain 00..0F with no gaps.
    drain(16, "drain1_cycles");
    chk("drain1_count", count, 0);
    chk("drain1_sb_empty", exp_q.size(), 0);

    // 20 writes / 20 reads across the pointer wrap; 0x77 is written while full with a pop.
    for (int i = 0; i < DEPTH; i++) wr(8'h40 + 8'(i), 1'b1);
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    chk("wrap_count13", count, 13);
    for (int i = 0; i < 3; i++) wr(8'h60 + 8'(i), 1'b1);
    chk("wrap_full", full, 1);
    out_ready = 1'b1;
    wr(8'h77, 1'b1);
    out_ready = 1'b0;
    chk("wrap_count_stays", count, 16);
    chk("wrap_no_overflow", overflow, 0);
    chk("wrap_full_again", full, 1);
    drain(16, "drain2_cycles");
    chk("drain2_sb_empty", exp_q.size(), 0);

    // Reset with 5 bytes stored discards them.
    for (int i = 0; i < 5; i++) wr(8'hB0 + 8'(i), 1'b0);
    chk("pre_reset_count", count, 5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_count", count, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_out_valid", out_valid, 0);
    wr(8'h3C, 1'b1);
    chk("post_rst_head", out_data, 8'h3C);
    drain(1, "drain3_cycles");
    chk("final_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
